stopwatch_bcd: RTL

- BCD stopwatch that consumes the one-cycle 10 ms rollover pulse from the upstream 10 ms timer.
- Counts centiseconds, seconds and minutes under a run/stop/clear control FSM.
- Provides a lap-hold (display freeze) while the live count keeps running.
- Outputs feed the seven-segment/display driver downstream.

---
 rtl/stopwatch_pkg.sv | 45 ++++
 rtl/stopwatch_bcd_if.sv | 35 +++
 rtl/stopwatch_bcd_cnt.sv | 35 +++
 rtl/stopwatch_bcd.sv | 128 ++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// STOPWATCH_HOURS_EN widens the time record with an hours field.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } sw_state_e;

    localparam logic [7:0] CS_MAX  = 8'h99;
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h99;

`ifdef STOPWATCH_HOURS_EN
    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sec;
        logic [7:0] cs;
    } sw_time_t;
`else
    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] sec;
        logic [7:0] cs;
    } sw_time_t;
`endif

    // Two-digit BCD +1; each nibble wraps 9 -> 0 so no binary codes appear.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Control pulses and display outputs of the stopwatch.
// STOPWATCH_HOURS_EN adds the hr_bcd display field.
interface stopwatch_bcd_if;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [7:0] cs_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       running;
    logic       lap_active;
    logic       overflow;
`ifdef STOPWATCH_HOURS_EN
    logic [7:0] hr_bcd;

    modport master (
        output tick, start_stop, clear, lap,
        input  cs_bcd, sec_bcd, min_bcd, hr_bcd, running, lap_active, overflow
    );
    modport slave (
        input  tick, start_stop, clear, lap,
        output cs_bcd, sec_bcd, min_bcd, hr_bcd, running, lap_active, overflow
    );
`else
    modport master (
        output tick, start_stop, clear, lap,
        input  cs_bcd, sec_bcd, min_bcd, running, lap_active, overflow
    );
    modport slave (
        input  tick, start_stop, clear, lap,
        output cs_bcd, sec_bcd, min_bcd, running, lap_active, overflow
    );
`endif
endinterface

// File: rtl/stopwatch_bcd_cnt.sv
// Two-digit BCD counter wrapping at MAX; carry_o flags the wrapping increment.
module stopwatch_bcd_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] value_o,
    output logic       carry_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = (value_q == MAX) ? 8'h00 : bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value_o = value_q;
    assign carry_o = inc_i && (value_q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch: run/stop/clear FSM, cs/sec/min carry chain and lap hold.
// STOPWATCH_HOURS_EN adds an hours digit pair; overflow then fires on the hours wrap.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] MIN_LIMIT = 8'h59
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_bcd_if.slave  sw
);

    sw_state_e state_q, state_d;
    logic      lap_q, lap_d;
    logic      ovf_q, ovf_d;
    sw_time_t  held_q, held_d;
    sw_time_t  live;
    sw_time_t  disp;

    logic       running;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       capture;
    logic       wrap;
    logic [7:0] cs_v, sec_v, min_v;
    logic       cs_c, sec_c, min_c;

    stopwatch_bcd_cnt #(.MAX(CS_MAX)) u_cs (
        .clk(clk), .rst(reset), .inc_i(cnt_inc), .clr_i(cnt_clr),
        .value_o(cs_v), .carry_o(cs_c)
    );
    stopwatch_bcd_cnt #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(reset), .inc_i(cs_c), .clr_i(cnt_clr),
        .value_o(sec_v), .carry_o(sec_c)
    );
    stopwatch_bcd_cnt #(.MAX(MIN_LIMIT)) u_min (
        .clk(clk), .rst(reset), .inc_i(sec_c), .clr_i(cnt_clr),
        .value_o(min_v), .carry_o(min_c)
    );

`ifdef STOPWATCH_HOURS_EN
    logic [7:0] hr_v;
    logic       hr_c;

    stopwatch_bcd_cnt #(.MAX(HR_MAX)) u_hr (
        .clk(clk), .rst(reset), .inc_i(min_c), .clr_i(cnt_clr),
        .value_o(hr_v), .carry_o(hr_c)
    );
    assign live = {hr_v, min_v, sec_v, cs_v};
    assign wrap = hr_c;
`else
    assign live = {min_v, sec_v, cs_v};
    assign wrap = min_c;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sw.start_stop) state_d = RUN;
            RUN:     if (sw.start_stop) state_d = STOP;
            STOP: begin
                // clear outranks start_stop in the same cycle
                if (sw.clear)           state_d = IDLE;
                else if (sw.start_stop) state_d = RUN;
            end
            default:                    state_d = IDLE;
        endcase
    end

    // Counting keys off the registered state, so a tick on the entering
    // start_stop is dropped and one on the leaving start_stop is kept.
    always_comb begin
        running = (state_q == RUN);
        cnt_inc = running && sw.tick;
        cnt_clr = (state_q == STOP) && sw.clear;
        lap_d   = lap_q;
        capture = 1'b0;
        case (state_q)
            RUN: begin
                if (sw.lap) begin
                    lap_d   = !lap_q;
                    capture = !lap_q;
                end
            end
            STOP: begin
                if (sw.clear || (sw.lap && lap_q)) lap_d = 1'b0;
            end
            default: ;
        endcase

        ovf_d = ovf_q;
        if (cnt_clr)   ovf_d = 1'b0;
        else if (wrap) ovf_d = 1'b1;

        held_d = held_q;
        if (cnt_clr)      held_d = '0;
        else if (capture) held_d = live;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q  <= 1'b0;
            ovf_q  <= 1'b0;
            held_q <= '0;
        end else begin
            lap_q  <= lap_d;
            ovf_q  <= ovf_d;
            held_q <= held_d;
        end
    end

    assign disp          = lap_q ? held_q : live;
    assign sw.cs_bcd     = disp.cs;
    assign sw.sec_bcd    = disp.sec;
    assign sw.min_bcd    = disp.mn;
`ifdef STOPWATCH_HOURS_EN
    assign sw.hr_bcd     = disp.hr;
`endif
    assign sw.running    = running;
    assign sw.lap_active = lap_q;
    assign sw.overflow   = ovf_q;

endmodule
